// File: rtl/uart_pkg.sv
// Shared register map, bit indices and transmitter state encoding for the UART TX responder.
package uart_pkg;
  localparam logic [4:0]  TXDATA_OFS   = 5'h00;
  localparam logic [4:0]  STATUS_OFS   = 5'h08;
  localparam logic [4:0]  CTRL_OFS     = 5'h10;
  localparam logic [63:0] WINDOW_BYTES = 64'd24;

  localparam int ST_BUSY   = 0;
  localparam int ST_FULL   = 1;
  localparam int ST_EMPTY  = 2;
  localparam int ST_OVF    = 3;
  localparam int ST_LVL    = 4;
  localparam int ST_PARITY = 8;

  localparam int CTRL_IRQ_EN = 0;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;
endpackage

// File: rtl/uart_tx_bus_responder_fifo.sv
// Synchronous FIFO with occupancy count; push while full and pop while empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic             do_push, do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end
endmodule

// File: rtl/uart_tx_bus_responder.sv
// Memory-mapped 8N1 UART transmitter with TX FIFO and drain interrupt.
// Define UART_TX_PARITY_EN to append an even-parity bit before the stop bit.
module uart_tx_bus_responder
  import uart_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR    = 64'h8000_0000,
  parameter int          CLKS_PER_BIT = 434,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [3:0]  IRQ_VECTOR   = 4'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] bus_address,
  input  logic [63:0] bus_write_data,
  input  logic        bus_write_enable,
  input  logic        bus_read_enable,
  output logic [63:0] bus_read_data,
  output logic        tx,
  output logic [3:0]  irq_vector,
  input  logic        irq_ack
);
  localparam int             CW       = $clog2(CLKS_PER_BIT);
  localparam int             LW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(CLKS_PER_BIT - 1);

  logic [63:0] ofs, status;
  logic        in_win, wr_tx, wr_ctrl, rd_status, rd_ctrl;
  logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]  fifo_rdata;
  logic [LW-1:0] fifo_level;
  logic [31:0] lvl32;
  logic        overflow, irq_en, irq_pending;

  tx_state_e   state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]  bit_idx, bit_n;
  logic [7:0]  shift, shift_n;
  logic        par, par_n, tx_n, load, frame_end, cnt_done;

  assign ofs       = bus_address - BASE_ADDR;
  assign in_win    = (bus_address >= BASE_ADDR) && (ofs < WINDOW_BYTES) && (bus_address[2:0] == 3'b0);
  assign wr_tx     = bus_write_enable && in_win && (ofs[4:0] == TXDATA_OFS);
  assign wr_ctrl   = bus_write_enable && in_win && (ofs[4:0] == CTRL_OFS);
  assign rd_status = bus_read_enable  && in_win && (ofs[4:0] == STATUS_OFS);
  assign rd_ctrl   = bus_read_enable  && in_win && (ofs[4:0] == CTRL_OFS);
  assign fifo_push = wr_tx && !fifo_full;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(fifo_push), .pop(fifo_pop), .wdata(bus_write_data[7:0]),
    .rdata(fifo_rdata), .full(fifo_full), .empty(fifo_empty), .level(fifo_level)
  );

  assign lvl32 = 32'(fifo_level);

  always_comb begin
    status                 = '0;
    status[ST_BUSY]        = (state != IDLE);
    status[ST_FULL]        = fifo_full;
    status[ST_EMPTY]       = fifo_empty;
    status[ST_OVF]         = overflow;
    status[ST_LVL +: 4]    = (lvl32 > 32'd15) ? 4'hF : lvl32[3:0];
`ifdef UART_TX_PARITY_EN
    status[ST_PARITY]      = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus_read_data <= '0;
      overflow      <= 1'b0;
      irq_en        <= 1'b0;
      irq_pending   <= 1'b0;
    end else begin
      if (bus_read_enable)
        bus_read_data <= rd_status ? status : rd_ctrl ? {63'b0, irq_en} : 64'b0;
      // the drop marker wins over a same-cycle STATUS read so no overflow is lost
      if (wr_tx && fifo_full) overflow <= 1'b1;
      else if (rd_status)     overflow <= 1'b0;
      if (wr_ctrl) irq_en <= bus_write_data[CTRL_IRQ_EN];
      if (frame_end && fifo_empty && irq_en) irq_pending <= 1'b1;
      else if (irq_ack || wr_ctrl)           irq_pending <= 1'b0;
    end
  end

  assign irq_vector = irq_pending ? IRQ_VECTOR : 4'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      par     <= 1'b0;
      tx      <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
      shift   <= shift_n;
      par     <= par_n;
      tx      <= tx_n;
    end
  end

  assign cnt_done = (cnt == CNT_LAST);
  assign fifo_pop = load;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_n     = bit_idx;
    shift_n   = shift;
    par_n     = par;
    tx_n      = tx;
    load      = 1'b0;
    frame_end = 1'b0;
    case (state)
      IDLE: load = !fifo_empty;
      START:
        if (cnt_done) begin
          cnt_n = '0; bit_n = '0; tx_n = shift[0]; state_n = DATA;
        end else cnt_n = cnt + 1'b1;
      DATA:
        if (cnt_done) begin
          cnt_n = '0;
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_n = PARITY; tx_n = par;
`else
            state_n = STOP; tx_n = 1'b1;
`endif
          end else begin
            // shifter keeps the bit on the wire at [0], so the next one is [1]
            bit_n = bit_idx + 1'b1; shift_n = shift >> 1; tx_n = shift[1];
          end
        end else cnt_n = cnt + 1'b1;
      PARITY:
        if (cnt_done) begin
          cnt_n = '0; state_n = STOP; tx_n = 1'b1;
        end else cnt_n = cnt + 1'b1;
      STOP:
        if (cnt_done) begin
          frame_end = 1'b1;
          if (fifo_empty) begin
            state_n = IDLE; cnt_n = '0;
          end else load = 1'b1;
        end else cnt_n = cnt + 1'b1;
      default: state_n = IDLE;
    endcase
    if (load) begin
      state_n = START; cnt_n = '0; shift_n = fifo_rdata; par_n = ^fifo_rdata; tx_n = 1'b0;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{bus_write_data[63:8], ofs[63:5]};
endmodule

// File: tb/tb_uart_tx_bus_responder.sv
// Scoreboard bench: bytes written to TXDATA are queued and checked against frames decoded from tx.
module tb_uart_tx_bus_responder;
  localparam int          CPB   = 4;
  localparam int          DEPTH = 8;
  localparam logic [63:0] BASE  = 64'h8000_0000;
`ifdef UART_TX_PARITY_EN
  localparam int          FB    = 11;
  localparam logic [63:0] PAR   = 64'h100;
`else
  localparam int          FB    = 10;
  localparam logic [63:0] PAR   = 64'h0;
`endif

  logic        clk = 1'b0, reset = 1'b1;
  logic [63:0] bus_address = '0, bus_write_data = '0, bus_read_data;
  logic        bus_write_enable = 1'b0, bus_read_enable = 1'b0, tx, irq_ack = 1'b0;
  logic [3:0]  irq_vector;

  uart_tx_bus_responder #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .IRQ_VECTOR(4'd1)) dut (
    .clk(clk), .reset(reset), .bus_address(bus_address), .bus_write_data(bus_write_data),
    .bus_write_enable(bus_write_enable), .bus_read_enable(bus_read_enable),
    .bus_read_data(bus_read_data), .tx(tx), .irq_vector(irq_vector), .irq_ack(irq_ack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_tests = 0, n_fail = 0, epoch = 0;
  logic [7:0] sb[$];
  int         starts[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [63:0] a, input logic [63:0] d);
    @(negedge clk);
    bus_address = a; bus_write_data = d; bus_write_enable = 1'b1;
    @(negedge clk);
    bus_write_enable = 1'b0;
  endtask

  task automatic bus_rd(input logic [63:0] a, output logic [63:0] d);
    @(negedge clk);
    bus_address = a; bus_read_enable = 1'b1;
    @(negedge clk);
    bus_read_enable = 1'b0;
    d = bus_read_data;
  endtask

  task automatic send(input logic [7:0] b);
    bus_wr(BASE, {56'b0, b});
    sb.push_back(b);
  endtask

  task automatic wait_idle();
    logic [63:0] st;
    logic        done;
    done = 1'b0;
    for (int i = 0; i < 4000 && !done; i++) begin
      bus_rd(BASE + 64'h8, st);
      if (!st[0] && st[2]) done = 1'b1;
    end
    chk("idle_timeout", {63'b0, done}, 64'd1);
  endtask

  // Frame decoder: samples mid-bit, frames aborted by reset are discarded.
  logic [7:0] m_d;
  logic       m_start, m_stop, m_par;
  int         m_ep;
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && tx === 1'b0) begin
        m_ep = epoch;
        starts.push_back(cyc);
        repeat (CPB/2) @(negedge clk);
        m_start = tx;
        for (int j = 0; j < 8; j++) begin
          repeat (CPB) @(negedge clk);
          m_d[j] = tx;
        end
`ifdef UART_TX_PARITY_EN
        repeat (CPB) @(negedge clk);
        m_par = tx;
`else
        m_par = 1'b0;
`endif
        repeat (CPB) @(negedge clk);
        m_stop = tx;
        if (m_ep == epoch) begin
          chk("start_bit", {63'b0, m_start}, 64'd0);
          chk("sb_avail", {63'b0, sb.size() > 0}, 64'd1);
          if (sb.size() > 0) begin
`ifdef UART_TX_PARITY_EN
            chk("parity_bit", {63'b0, m_par}, {63'b0, ^sb[0]});
`endif
            chk("data", {56'b0, m_d}, {56'b0, sb.pop_front()});
          end
          chk("stop_bit", {63'b0, m_stop}, 64'd1);
        end
        repeat (CPB - CPB/2 - 1) @(negedge clk);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [63:0] rd;
  logic        found;
  int          t_irq;

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_tx", {63'b0, tx}, 64'd1);
    chk("rst_irq", {60'b0, irq_vector}, 64'd0);
    chk("rst_rdata", bus_read_data, 64'd0);
    bus_rd(BASE + 64'h8, rd);  chk("rst_status", rd, 64'h04 | PAR);

    // decode: holes, misalignment, out of window, write-only TXDATA
    bus_rd(BASE + 64'h18, rd); chk("rd_0x18", rd, 64'd0);
    bus_rd(BASE + 64'h4, rd);  chk("rd_0x04", rd, 64'd0);
    bus_rd(BASE, rd);          chk("rd_txdata", rd, 64'd0);
    bus_rd(64'h8, rd);         chk("rd_outside", rd, 64'd0);
    bus_wr(BASE + 64'h4, 64'h55);
    bus_wr(BASE + 64'h18, 64'h55);
    bus_wr(64'h0, 64'h55);
    bus_rd(BASE + 64'h8, rd);  chk("bad_wr_ignored", rd, 64'h04 | PAR);

    // single byte: latency and busy
    starts.delete();
    bus_wr(BASE, 64'h41);
    sb.push_back(8'h41);
    chk("lat_pre", {63'b0, tx}, 64'd1);
    @(negedge clk);
    chk("lat_fall", {63'b0, tx}, 64'd0);
    bus_rd(BASE + 64'h8, rd);  chk("busy_frame", {63'b0, rd[0]}, 64'd1);
    wait_idle();
    bus_rd(BASE + 64'h8, rd);  chk("status_after", rd, 64'h04 | PAR);

    // three back-to-back frames, level drains 2,1,0
    starts.delete();
    send(8'hA0); send(8'h5F); send(8'hC3);
    bus_rd(BASE + 64'h8, rd);  chk("lvl_2", {60'b0, rd[7:4]}, 64'd2);
    repeat (CPB*FB - 2) @(negedge clk);
    bus_rd(BASE + 64'h8, rd);  chk("lvl_1", {60'b0, rd[7:4]}, 64'd1);
    repeat (CPB*FB - 2) @(negedge clk);
    bus_rd(BASE + 64'h8, rd);  chk("lvl_0", {60'b0, rd[7:4]}, 64'd0);
    wait_idle();
    chk("b2b_frames", 64'(starts.size()), 64'd3);
    if (starts.size() >= 3) begin
      chk("b2b_gap1", 64'(starts[1] - starts[0]), 64'(CPB*FB));
      chk("b2b_gap2", 64'(starts[2] - starts[1]), 64'(CPB*FB));
    end

    // overflow: one in flight, FIFO filled, extra byte dropped
    send(8'h01);
    for (int i = 1; i <= DEPTH; i++) send(8'(8'h10 + i));
    bus_wr(BASE, 64'hEE);
    bus_rd(BASE + 64'h8, rd);  chk("ovf_status", rd, 64'h8B | PAR);
    bus_rd(BASE + 64'h8, rd);  chk("ovf_cleared", rd, 64'h83 | PAR);
    wait_idle();

    // interrupt on drain, ack clear, CTRL-write clear, disabled
    bus_wr(BASE + 64'h10, 64'h1);
    bus_rd(BASE + 64'h10, rd); chk("ctrl_rd", rd, 64'd1);
    starts.delete();
    send(8'h5A);
    found = 1'b0; t_irq = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (irq_vector == 4'd1) begin found = 1'b1; t_irq = cyc; end
    end
    chk("irq_seen", {63'b0, found}, 64'd1);
    chk("irq_start_seen", 64'(starts.size()), 64'd1);
    if (starts.size() > 0) chk("irq_time", 64'(t_irq - starts[0]), 64'(CPB*FB));
    @(negedge clk); irq_ack = 1'b1;
    @(negedge clk); irq_ack = 1'b0;
    chk("irq_ack_clr", {60'b0, irq_vector}, 64'd0);
    send(8'h96);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (irq_vector == 4'd1) found = 1'b1;
    end
    chk("irq_seen2", {63'b0, found}, 64'd1);
    bus_wr(BASE + 64'h10, 64'h0);
    chk("irq_ctrl_clr", {60'b0, irq_vector}, 64'd0);
    send(8'h77);
    wait_idle();
    repeat (5) @(negedge clk);
    chk("irq_disabled", {60'b0, irq_vector}, 64'd0);

    // reset mid-DATA with a byte queued and an interrupt pending
    bus_wr(BASE + 64'h10, 64'h1);
    send(8'h3E);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (irq_vector == 4'd1) found = 1'b1;
    end
    chk("irq_pre_rst", {63'b0, found}, 64'd1);
    send(8'hA5); send(8'h3C);
    repeat (12) @(negedge clk);
    epoch++;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    chk("midrst_tx", {63'b0, tx}, 64'd1);
    chk("midrst_irq", {60'b0, irq_vector}, 64'd0);
    bus_rd(BASE + 64'h8, rd);  chk("midrst_status", rd, 64'h04 | PAR);
    bus_rd(BASE + 64'h10, rd); chk("midrst_ctrl", rd, 64'd0);
    repeat (CPB*FB + 4) @(negedge clk);
    chk("midrst_tx_quiet", {63'b0, tx}, 64'd1);

`ifdef UART_TX_PARITY_EN
    send(8'h07);
    wait_idle();
`endif
    send(8'hFF);
    send(8'h00);
    wait_idle();
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
